// File: rtl/contador_seq.sv
// rtl/contador_seq.sv - sweep sequencer driving one contador up/down counter
module contador_seq #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] top,
  input  logic [WIDTH-1:0] bottom,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  input  logic [WIDTH-1:0] cont,
  output logic             enable,
  output logic             updown,
  output logic             load,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_n;

  // Run configuration, captured once at start so the host may change its
  // inputs while a run is in progress.
  logic [WIDTH-1:0] top_q;
  logic [WIDTH-1:0] bottom_q;
  logic [REP_W-1:0] reps_q;
  logic [WIDTH-1:0] data_q;

  logic             cfg_ok;
  logic             accept;
  logic             at_top;
  logic             at_bottom;
  logic [REP_W-1:0] pass_inc;
  logic             last_pass;
  logic             pass_hit;

  assign cfg_ok    = (bottom < top) && (bottom <= start_val) &&
                     (start_val <= top) && (reps != '0);
  assign accept    = (state == S_IDLE) && start && cfg_ok;
  assign at_top    = (cont == top_q);
  assign at_bottom = (cont == bottom_q);

  // Saturating increment; the counter can never actually pass reps_q.
  assign pass_inc  = (pass_cnt == '1) ? pass_cnt : pass_cnt + REP_W'(1);
  assign last_pass = (pass_inc == reps_q);

  // Abort outranks the pass completion seen in the same cycle.
  assign pass_hit  = (state == S_DOWN) && !abort && at_bottom;

  // Load data lines: a is the MSB, d the LSB.
  assign {a, b, c, d} = data_q[WIDTH-1 -: 4];

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus state/cont-decoded counter controls and status.
  always_comb begin
    state_n = state;
    enable  = 1'b0;
    updown  = 1'b1;
    load    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          load    = 1'b1;
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy    = 1'b1;
        state_n = abort ? S_IDLE : S_UP;
      end
      S_UP: begin
        busy = 1'b1;
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          enable = 1'b1;
          if (at_top) begin
            // Turn around on the top value itself, no dwell cycle.
            updown  = 1'b0;
            state_n = S_DOWN;
          end
        end
      end
      S_DOWN: begin
        busy = 1'b1;
        if (abort) begin
          state_n = S_IDLE;
        end else if (!at_bottom) begin
          enable = 1'b1;
          updown = 1'b0;
        end else if (last_pass) begin
          // Final pass: leave the counter parked on bottom.
          updown  = 1'b0;
          state_n = S_DONE;
        end else begin
          enable  = 1'b1;
          state_n = S_UP;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Config latch, load data, pass counter and the reject pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      top_q    <= '0;
      bottom_q <= '0;
      reps_q   <= '0;
      data_q   <= '0;
      pass_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= (state == S_IDLE) && start && !cfg_ok;
      if (accept) begin
        top_q    <= top;
        bottom_q <= bottom;
        reps_q   <= reps;
        data_q   <= start_val;
        pass_cnt <= '0;
      end else if (pass_hit) begin
        pass_cnt <= pass_inc;
      end
    end
  end

endmodule

// File: tb/tb_contador_seq.sv
// tb/tb_contador_seq.sv - randomized and directed checks of contador_seq against a schedule model
module tb_contador_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] start_val;
  logic [3:0] top;
  logic [3:0] bottom;
  logic [3:0] reps;
  logic [3:0] cont = 4'd0;
  logic       enable;
  logic       updown;
  logic       load;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] pass_cnt;

  int total = 0;
  int bad   = 0;
  bit check_on = 1'b0;

  contador_seq #(.WIDTH(4), .REP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .start_val(start_val),
    .top(top), .bottom(bottom), .reps(reps), .abort(abort), .cont(cont),
    .enable(enable), .updown(updown), .load(load),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt)
  );

  // Behavioural contador: synchronous load, else +/-1 when enabled.
  always @(posedge clk) begin
    if (load) cont <= {a, b, c, d};
    else if (enable) cont <= updown ? cont + 4'd1 : cont - 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One expected cycle of a run.
  typedef struct packed {
    logic       en;
    logic       ud;
    logic       ld;
    logic       bsy;
    logic       dn;
    logic       care;
    logic [3:0] pc;
    logic [3:0] cv;
  } rec_t;

  rec_t       sched[$];
  logic [3:0] m_pass = 4'd0;
  logic [3:0] m_data = 4'd0;
  bit         m_err  = 1'b0;

  // Precompute a whole run as a list of cycles by walking the counter value.
  task automatic build(input int sv, input int t, input int bt, input int r);
    rec_t e;
    int   v;
    int   p;
    bit   up;
    sched.delete();
    e = '0; e.ld = 1'b1; e.bsy = 1'b1;
    sched.push_back(e);
    e = '0; e.bsy = 1'b1; e.care = 1'b1; e.cv = sv[3:0];
    sched.push_back(e);
    v = sv; p = 0; up = 1'b1;
    for (int guard = 0; guard < 2000; guard++) begin
      e = '0; e.bsy = 1'b1; e.care = 1'b1; e.cv = v[3:0]; e.pc = p[3:0];
      if (up) begin
        e.en = 1'b1;
        if (v == t) begin e.ud = 1'b0; v--; up = 1'b0; end
        else begin e.ud = 1'b1; v++; end
        sched.push_back(e);
      end else if (v != bt) begin
        e.en = 1'b1; e.ud = 1'b0; v--;
        sched.push_back(e);
      end else begin
        p++;
        if (p == r) begin
          sched.push_back(e);
          break;
        end
        e.en = 1'b1; e.ud = 1'b1; v++; up = 1'b1;
        sched.push_back(e);
      end
    end
    e = '0; e.dn = 1'b1; e.care = 1'b1; e.cv = bt[3:0]; e.pc = r[3:0];
    sched.push_back(e);
  endtask

  // Compare process: every cycle, DUT outputs against the model's schedule.
  initial begin
    forever begin
      rec_t e;
      bit   act;
      bit   ab;
      bit   ok;
      @(negedge clk);
      act = sched.size() > 0;
      if (act) e = sched[0];
      else begin e = '0; e.pc = m_pass; end
      ab = act && e.bsy && abort;
      if (ab) begin e.en = 1'b0; e.ld = 1'b0; end
      if (check_on) begin
        chk("enable", int'(enable), int'(e.en));
        chk("load", int'(load), int'(e.ld));
        chk("busy", int'(busy), int'(e.bsy));
        chk("done", int'(done), int'(e.dn));
        chk("err", int'(err), int'(m_err));
        chk("pass_cnt", int'(pass_cnt), int'(e.pc));
        chk("abcd", int'({a, b, c, d}), int'(m_data));
        if (e.en) chk("updown", int'(updown), int'(e.ud));
        if (e.care) chk("cont", int'(cont), int'(e.cv));
      end
      if (!reset) begin
        sched.delete();
        m_pass = 4'd0;
        m_data = 4'd0;
        m_err  = 1'b0;
      end else begin
        ok = (bottom < top) && (bottom <= start_val) && (start_val <= top) && (reps != 4'd0);
        m_err = !act && start && !ok;
        if (act) begin
          m_pass = e.pc;
          if (ab) sched.delete();
          else void'(sched.pop_front());
        end else if (start && ok) begin
          build(int'(start_val), int'(top), int'(bottom), int'(reps));
          m_data = start_val;
        end
      end
    end
  end

  task automatic do_start(input logic [3:0] sv, input logic [3:0] t,
                          input logic [3:0] bt, input logic [3:0] r);
    @(posedge clk); #1;
    start = 1'b1; start_val = sv; top = t; bottom = bt; reps = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles from the LOAD cycle to the done pulse; optionally pulses a
  // conflicting start mid-run.
  task automatic wait_done(input int inj, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (done) begin got = 1'b1; break; end
      if (n == inj) begin
        @(posedge clk); #1;
        start = 1'b1; start_val = 4'd0; top = 4'd15; bottom = 4'd0; reps = 4'd5;
      end else if (start) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("done_seen", int'(got), 1);
  endtask

  task automatic reject(input logic [3:0] sv, input logic [3:0] t,
                        input logic [3:0] bt, input logic [3:0] r);
    logic [3:0] pc0;
    pc0 = pass_cnt;
    do_start(sv, t, bt, r);
    @(negedge clk);
    chk("rej_err", int'(err), 1);
    chk("rej_busy", int'(busy), 0);
    @(negedge clk);
    chk("rej_err_end", int'(err), 0);
    chk("rej_busy2", int'(busy), 0);
    chk("rej_pass", int'(pass_cnt), int'(pc0));
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    start_val = 4'd0; top = 4'd0; bottom = 4'd0; reps = 4'd0;

    // Pin the schedule model: 5..9..2..9..2 is LOAD, SETTLE, 26 sweep cycles, DONE.
    build(5, 9, 2, 2);
    chk("model_len", sched.size(), 29);
    chk("model_done", int'(sched[28].dn), 1);
    chk("model_last_en", int'(sched[27].en), 0);
    chk("model_first_up_cont", int'(sched[2].cv), 5);
    sched.delete();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_updown", int'(updown), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_pass", int'(pass_cnt), 0);
    chk("rst_abcd", int'({a, b, c, d}), 0);
    check_on = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;

    // Normal run: done 3 cycles (start, LOAD, SETTLE) plus 26 after first UP.
    do_start(4'd5, 4'd9, 4'd2, 4'd2);
    wait_done(0, n);
    chk("norm_latency", n, 29);
    chk("norm_pass", int'(pass_cnt), 2);
    chk("norm_cont", int'(cont), 2);
    @(negedge clk);
    chk("norm_idle_busy", int'(busy), 0);
    chk("norm_hold", int'(cont), 2);

    // Start at top: immediate turn, 7 down to 0.
    do_start(4'd7, 4'd7, 4'd0, 4'd1);
    wait_done(0, n);
    chk("edge_latency", n, 11);
    chk("edge_cont", int'(cont), 0);

    reject(4'd4, 4'd4, 4'd4, 4'd1);
    reject(4'd5, 4'd9, 4'd2, 4'd0);
    reject(4'd10, 4'd9, 4'd2, 4'd1);

    // Abort in the second down sweep at cont=6.
    do_start(4'd5, 4'd9, 4'd2, 4'd2);
    repeat (23) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(negedge clk);
    chk("abort_cont", int'(cont), 6);
    chk("abort_enable", int'(enable), 0);
    chk("abort_busy", int'(busy), 1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    chk("abort_nodone", int'(done), 0);
    chk("abort_hold", int'(cont), 6);
    chk("abort_pass", int'(pass_cnt), 1);

    // Start while busy is ignored.
    do_start(4'd5, 4'd9, 4'd2, 4'd2);
    wait_done(5, n);
    chk("ignstart_latency", n, 29);
    chk("ignstart_pass", int'(pass_cnt), 2);

    // Reset during UP, then a clean run starting at bottom.
    do_start(4'd3, 4'd8, 4'd1, 4'd1);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_enable", int'(enable), 0);
    chk("midrst_updown", int'(updown), 1);
    chk("midrst_pass", int'(pass_cnt), 0);
    chk("midrst_abcd", int'({a, b, c, d}), 0);
    do_start(4'd2, 4'd6, 4'd2, 4'd1);
    wait_done(0, n);
    chk("bottom_start_latency", n, 12);

    // Randomized runs with sporadic aborts and ignored starts.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] rb;
      logic [3:0] rt;
      logic [3:0] rs;
      logic [3:0] rr;
      bit         bz;
      bit         ab;
      bit         fin;
      if ($urandom_range(0, 3) != 0) begin
        rb = 4'($urandom_range(0, 13));
        rt = 4'($urandom_range(int'(rb) + 1, 15));
        rs = 4'($urandom_range(int'(rb), int'(rt)));
        rr = 4'($urandom_range(1, 3));
      end else begin
        rb = 4'($urandom);
        rt = 4'($urandom);
        rs = 4'($urandom);
        rr = 4'($urandom_range(0, 3));
      end
      do_start(rs, rt, rb, rr);
      fin = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (!busy && !done) begin fin = 1'b1; break; end
        bz = busy;
        @(posedge clk); #1;
        ab = abort;
        abort = bz && ($urandom_range(0, 47) == 0);
        start = bz && !ab && ($urandom_range(0, 15) == 0);
        if (start) begin
          start_val = 4'($urandom); top = 4'($urandom);
          bottom = 4'($urandom); reps = 4'($urandom);
        end
      end
      chk("rand_run_ends", int'(fin), 1);
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/contador_seq.md
Name: contador_seq

Overview:
- Sequencing controller for the team's 4-bit up/down counter (`contador`: ports `enable`, `updown`, `load`, `a`/`b`/`c`/`d`, `cont`).
- Loads a start value, then sweeps the counter up to `top` and down to `bottom`, repeating for a programmed number of passes.
- Reports status to the host through a start/busy/done handshake.
- Sits between the host control logic and one `contador` instance. It drives all counter control inputs and reads `cont` back.

Parameters:
- `WIDTH`, 4, counter width. `a`/`b`/`c`/`d` mapping below is fixed for `WIDTH`=4.
- `REP_W`, 4, width of the repeat count and the pass counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request a run. Sampled only in IDLE.
- `start_val`  in  `WIDTH`  value loaded into the counter.
- `top`  in  `WIDTH`  upper turn-around value.
- `bottom`  in  `WIDTH`  lower turn-around value.
- `reps`  in  `REP_W`  number of passes to run.
- `abort`  in  1  terminate the run immediately.
- `cont`  in  `WIDTH`  counter value fed back from `contador`.
- `enable`  out  1  counter enable.
- `updown`  out  1  counter direction: 1 = up, 0 = down.
- `load`  out  1  counter synchronous load.
- `a`, `b`, `c`, `d`  out  1 each  load data: `a` = bit3 (MSB) through `d` = bit0.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  one-cycle pulse on rejected configuration.
- `pass_cnt`  out  `REP_W`  passes completed in the current or last run.

Behaviour:
- Counter contract:
  - `load` is synchronous: `cont` <= {`a`,`b`,`c`,`d`}.
  - `enable`=1 steps ±1 per clock.
  - The controller never asserts `load` and `enable` in the same cycle.
- Reset (`reset`=0 at a clock edge):
  - state = IDLE; `pass_cnt`=0; `err`=0; latched config = 0.
  - Outputs: `a`..`d`=0, `enable`=0, `load`=0, `updown`=1, `busy`=0, `done`=0.
  - Reset mid-run aborts silently; no `done` pulse.
- Config latch:
  - Taken in IDLE on `start`=1.
  - Valid iff `bottom` < `top`, `bottom` <= `start_val` <= `top`, and `reps` != 0.
  - Invalid config: `err`=1 for the next cycle, state stays IDLE, `pass_cnt` unchanged.
- `enable` and `updown` are decoded combinationally from state and `cont`. All other outputs are registered or state-decoded.
- States:
  - IDLE: `busy`=0, `enable`=0, `load`=0. Valid `start` -> LOAD; also latch config, clear `pass_cnt`, drive `a`..`d` = `start_val`.
  - LOAD: `load`=1, `enable`=0, `busy`=1. -> SETTLE.
  - SETTLE: `load`=0, `enable`=0 (`cont` now equals `start_val`). -> UP.
  - UP: `enable`=1.
    - `cont` != `top`: `updown`=1, stay in UP.
    - `cont` == `top`: `updown`=0, -> DOWN (immediate turn, no dwell at `top`).
  - DOWN: `enable`=1.
    - `cont` != `bottom`: `updown`=0, stay in DOWN.
    - `cont` == `bottom`: pass complete, `pass_cnt` += 1.
      - New `pass_cnt` == `reps`: `enable`=0, -> DONE.
      - Otherwise: `updown`=1, -> UP.
  - DONE: `done`=1, `busy`=0, `enable`=0. -> IDLE. The counter holds at `bottom`.
- `start_val` == `top`: the first UP cycle turns around immediately.
- `start_val` == `bottom`: normal up sweep.
- `abort`=1 in LOAD, SETTLE, UP or DOWN:
  - `enable`=0 and `load`=0 combinationally that cycle.
  - -> IDLE with no `done` pulse; `pass_cnt` keeps its value.
  - `abort` has priority over pass completion in the same cycle.
- Other start/abort cases:
  - `start` while `busy` is ignored.
  - `abort` in IDLE or DONE is ignored.
- `pass_cnt` saturates at its maximum value; unreachable in practice because `pass_cnt` never exceeds `reps`.
- The counter never wraps under controller operation because `bottom` < `top`.

Test Plan:
- Normal run: `start_val`=5, `top`=9, `bottom`=2, `reps`=2.
  - `load` high 1 cycle, then `cont` sequence 5,6,7,8,9,8,…,2,3,…,9,8,…,2.
  - `done` pulses exactly 26 cycles after the first UP cycle; `pass_cnt`=2; `cont` holds 2.
- Edge start: `start_val`=`top`=7, `bottom`=0, `reps`=1.
  - `cont` goes 7,6,…,0, then `done`; `cont` never reaches 8.
- Config rejection: `bottom`=`top`=4 -> `err` 1-cycle pulse, `busy` stays 0.
  - Repeat with `reps`=0 and with `start_val`=10, `top`=9: same result.
- Abort mid-sweep: `abort` in DOWN at `cont`=6.
  - `enable`=0 that cycle; `cont` holds 6; `busy`=0 next cycle; no `done`; `pass_cnt` retained.
- Ignored start: `start` pulsed while `busy` -> no reload, sequence unaffected.
- Reset mid-run: `reset`=0 for 1 cycle during UP.
  - All outputs return to reset values on that edge; the next `start` runs normally from LOAD.
